// File: rtl/rgb_pwm_ctrl_if.sv
// Key-pulse inputs, PWM tick enable and select/LED outputs of rgb_pwm_ctrl.
// The controller sits on the slave side; the debouncers and prescaler drive the master side.
interface rgb_pwm_ctrl_if;
    logic       ce_pwm;
    logic       key_sel;
    logic       key_up;
    logic       key_dn;
    logic [1:0] sel_out;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    modport master (
        output ce_pwm, key_sel, key_up, key_dn,
        input  sel_out, led_r, led_g, led_b
    );

    modport slave (
        input  ce_pwm, key_sel, key_up, key_dn,
        output sel_out, led_r, led_g, led_b
    );
endinterface

// File: rtl/rgb_pwm_ctrl.sv
// Three-channel RGB PWM controller: key pulses select a channel and step its duty;
// a shared period counter drives registered LED outputs with period-aligned duty updates.
module rgb_pwm_ctrl #(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned STEP      = 16,
    parameter int unsigned INIT_DUTY = 0
) (
    input logic           clk,
    input logic           clr,
    rgb_pwm_ctrl_if.slave bus
);

    localparam logic [PWM_W-1:0] CntMax   = {PWM_W{1'b1}};
    localparam logic [PWM_W:0]   StepExt  = (PWM_W + 1)'(STEP);
    localparam logic [PWM_W-1:0] InitDuty = PWM_W'(INIT_DUTY);

    typedef enum logic [1:0] {
        SelR = 2'd0,
        SelG = 2'd1,
        SelB = 2'd2
    } sel_e;

    sel_e             sel_q;
    logic [1:0]       chan;
    logic [PWM_W-1:0] duty_q [3];
    logic [PWM_W-1:0] duty_d [3];
    logic [PWM_W-1:0] act_q  [3];
    logic [PWM_W-1:0] cnt_q;
    logic [2:0]       led_q;

    logic [PWM_W-1:0] cur_duty;
    logic [PWM_W:0]   up_sum;
    logic [PWM_W-1:0] up_val;
    logic [PWM_W-1:0] dn_val;
    logic [PWM_W-1:0] new_duty;
    logic             adjust;
    logic             wrap;

    assign chan = sel_q;

    // Select FSM; an illegal encoding falls back to red on the next edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sel_q <= SelR;
        end else begin
            case (sel_q)
                SelR:    if (bus.key_sel) sel_q <= SelG;
                SelG:    if (bus.key_sel) sel_q <= SelB;
                SelB:    if (bus.key_sel) sel_q <= SelR;
                default: sel_q <= SelR;
            endcase
        end
    end

    always_comb begin
        cur_duty = '0;
        for (int i = 0; i < 3; i++) begin
            if (chan == 2'(i)) cur_duty = duty_q[i];
        end
    end

    // One-bit-wider sum so the saturation test cannot be fooled by a wrap.
    assign up_sum   = {1'b0, cur_duty} + StepExt;
    assign up_val   = up_sum[PWM_W] ? CntMax : up_sum[PWM_W-1:0];
    assign dn_val   = ({1'b0, cur_duty} < StepExt) ? '0 : (cur_duty - StepExt[PWM_W-1:0]);
    assign new_duty = bus.key_up ? up_val : dn_val;
    assign adjust   = (bus.key_up ^ bus.key_dn) && (chan != 2'd3);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            duty_d[i] = duty_q[i];
            if (adjust && (chan == 2'(i))) duty_d[i] = new_duty;
        end
    end

    assign wrap = bus.ce_pwm && (cnt_q == CntMax);

    // act captures the pre-edge duty, so a duty written on the wrap edge waits a period.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
            led_q <= '0;
            for (int i = 0; i < 3; i++) begin
                duty_q[i] <= InitDuty;
                act_q[i]  <= InitDuty;
            end
        end else begin
            if (bus.ce_pwm) cnt_q <= cnt_q + PWM_W'(1);
            for (int i = 0; i < 3; i++) begin
                duty_q[i] <= duty_d[i];
                if (wrap) act_q[i] <= duty_q[i];
                led_q[i] <= (cnt_q < act_q[i]);
            end
        end
    end

    assign bus.sel_out = chan;
    assign bus.led_r   = led_q[0];
    assign bus.led_g   = led_q[1];
    assign bus.led_b   = led_q[2];

`ifndef SYNTHESIS
    sel_legal_a: assert property (@(posedge clk) disable iff (!clr) chan != 2'd3);
`endif

endmodule
